// File: rtl/hex_text_writer_pkg.sv
// rtl/hex_text_writer_pkg.sv - shared types and constants for the hex text writer
package hex_text_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam int         MAX_DIGITS  = 8;
    localparam int         ROM_AW      = 12;

    // Requests for more digits than a 32-bit value holds print all eight.
    function automatic logic [3:0] clamp_len(input logic [3:0] l);
        return (l > 4'(MAX_DIGITS)) ? 4'(MAX_DIGITS) : l;
    endfunction

endpackage

// File: rtl/hex_text_writer_if.sv
// rtl/hex_text_writer_if.sv - hex-digit ROM lookup and text-buffer write port
//
// rom_addr  : writer -> ROM, {8'h00, nibble}
// rom_data  : ROM -> writer, ASCII code (combinational)
// txt_addr  : writer -> buffer, cell address
// txt_data  : writer -> buffer, character
// txt_we    : writer -> buffer, write request
// txt_ready : buffer -> writer, write accepted this cycle
interface hex_text_writer_if #(
    parameter int TEXT_AW = 12
);
    import hex_text_pkg::*;

    logic [ROM_AW-1:0]  rom_addr;
    logic [7:0]         rom_data;
    logic [TEXT_AW-1:0] txt_addr;
    logic [7:0]         txt_data;
    logic               txt_we;
    logic               txt_ready;

    modport master (
        output rom_addr,
        input  rom_data,
        output txt_addr,
        output txt_data,
        output txt_we,
        input  txt_ready
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  txt_addr,
        input  txt_data,
        input  txt_we,
        output txt_ready
    );

endinterface

// File: rtl/hex_text_writer.sv
// rtl/hex_text_writer.sv - renders a 32-bit value as hex ASCII into the text buffer
//
// clk, rst_n : clock, asynchronous active-low reset
// start      : request pulse, accepted only while idle
// value      : value to print (sampled on accepted start)
// len        : digit count, 0 = nothing, 9..15 treated as 8
// lz_blank   : print leading zeros as spaces
// base_addr  : cell of the most significant printed digit
// busy       : request in progress
// done       : one-cycle end-of-request pulse
// tif        : ROM lookup and text-buffer write port (master side)
module hex_text_writer
    import hex_text_pkg::*;
#(
    parameter int TEXT_AW = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [31:0]        value,
    input  logic [3:0]         len,
    input  logic               lz_blank,
    input  logic [TEXT_AW-1:0] base_addr,
    output logic               busy,
    output logic               done,
    hex_text_writer_if.master  tif
);

    state_t             state;
    logic [31:0]        shreg;
    logic [3:0]         cnt;
    logic [TEXT_AW-1:0] addr;
    logic               lead;

    logic [3:0] len_c;
    logic [5:0] shamt;
    logic [3:0] nib;
    logic       writing;

    assign len_c   = clamp_len(len);
    // Left-align the printed digits so the first one sits in shreg[31:28].
    assign shamt   = {4'(MAX_DIGITS) - len_c, 2'b00};
    assign nib     = shreg[31:28];
    assign writing = (state == WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            addr  <= '0;
            lead  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= value << shamt;
                        cnt   <= len_c;
                        addr  <= base_addr;
                        lead  <= lz_blank;
                        state <= (len_c != 4'd0) ? WRITE : DONE;
                    end
                end
                WRITE: begin
                    // A stalled write holds every register so the port stays stable.
                    if (tif.txt_ready) begin
                        shreg <= shreg << 4;
                        addr  <= addr + TEXT_AW'(1);
                        cnt   <= cnt - 4'd1;
                        lead  <= lead & (nib == 4'd0);
                        if (cnt == 4'd1) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy         = (state != IDLE);
        done         = (state == DONE);
        tif.txt_we   = writing;
        tif.txt_addr = writing ? addr : '0;
        tif.rom_addr = writing ? {{(ROM_AW-4){1'b0}}, nib} : '0;
        tif.txt_data = 8'h00;
        if (writing) begin
            // The final digit always comes from the ROM so zero prints as "0".
            if (lead && (nib == 4'd0) && (cnt != 4'd1)) begin
                tif.txt_data = ASCII_SPACE;
            end else begin
                tif.txt_data = tif.rom_data;
            end
        end
    end

endmodule

// File: tb/tb_hex_text_writer.sv
// tb/tb_hex_text_writer.sv - self-checking bench for hex_text_writer
module tb_hex_text_writer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] value;
    logic [3:0]  len;
    logic        lz_blank;
    logic [11:0] base_addr;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    hex_text_writer_if #(.TEXT_AW(12)) tif ();

    hex_text_writer #(.TEXT_AW(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .value     (value),
        .len       (len),
        .lz_blank  (lz_blank),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .tif       (tif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External hex-digit ROM.
    always_comb begin
        if (tif.rom_addr[3:0] < 4'd10) begin
            tif.rom_data = 8'h30 + {4'h0, tif.rom_addr[3:0]};
        end else begin
            tif.rom_data = 8'h37 + {4'h0, tif.rom_addr[3:0]};
        end
    end

    typedef struct {
        string       name;
        logic [31:0] value;
        logic [3:0]  len;
        logic        lz;
        logic [11:0] base;
        int          nexp;
        logic [63:0] chars;
        int          done_cyc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Issue one request and check every accepted write against the expected text.
    // st_lo..st_hi: cycles with txt_ready low; j1/j2: cycles with a spurious start.
    task automatic run(input string nm, input logic [31:0] v, input logic [3:0] l,
                       input logic lz, input logic [11:0] b, input int nexp,
                       input logic [63:0] exp_chars, input int exp_done,
                       input int st_lo, input int st_hi, input int j1, input int j2);
        logic [11:0] w_addr[8];
        logic [7:0]  w_data[8];
        int          w_cyc[8];
        int          nw;
        int          done_k;
        logic        prev_stall;
        logic [11:0] prev_addr;
        logic [7:0]  prev_data;

        nw = 0;
        done_k = 0;
        prev_stall = 1'b0;
        prev_addr = '0;
        prev_data = '0;

        @(negedge clk);
        start = 1'b1;
        value = v;
        len = l;
        lz_blank = lz;
        base_addr = b;
        tif.txt_ready = 1'b1;
        @(posedge clk);

        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == j1 || k == j2) begin
                start = 1'b1;
                value = 32'hFFFF_FFFF;
                len = 4'd1;
                lz_blank = 1'b0;
                base_addr = 12'h300;
            end else begin
                start = 1'b0;
                value = $urandom;
                len = 4'($urandom_range(0, 15));
                lz_blank = 1'($urandom_range(0, 1));
                base_addr = 12'($urandom);
            end
            tif.txt_ready = !(k >= st_lo && k <= st_hi);
            if (prev_stall) begin
                chk($sformatf("%s stall_we c%0d", nm, k), 32'(tif.txt_we), 32'd1);
                chk($sformatf("%s stall_addr c%0d", nm, k), 32'(tif.txt_addr), 32'(prev_addr));
                chk($sformatf("%s stall_data c%0d", nm, k), 32'(tif.txt_data), 32'(prev_data));
            end
            prev_stall = tif.txt_we && !tif.txt_ready;
            prev_addr = tif.txt_addr;
            prev_data = tif.txt_data;
            if (tif.txt_we && tif.txt_ready) begin
                if (nw < 8) begin
                    w_addr[nw] = tif.txt_addr;
                    w_data[nw] = tif.txt_data;
                    w_cyc[nw] = k;
                end
                nw++;
            end
            if (done) begin
                done_k = k;
                chk($sformatf("%s busy_in_done", nm), 32'(busy), 32'd1);
                break;
            end
        end

        chk($sformatf("%s done_cycle", nm), 32'(done_k), 32'(exp_done));
        chk($sformatf("%s write_count", nm), 32'(nw), 32'(nexp));
        if (nexp > 0 && nw > 0) begin
            chk($sformatf("%s first_write_cycle", nm), 32'(w_cyc[0]), 32'd1);
        end
        for (int i = 0; i < nexp && i < nw && i < 8; i++) begin
            chk($sformatf("%s char%0d", nm, i), 32'(w_data[i]),
                32'(exp_chars[8*(nexp-1-i) +: 8]));
            chk($sformatf("%s addr%0d", nm, i), 32'(w_addr[i]), 32'(12'(b + 12'(i))));
        end

        @(negedge clk);
        start = 1'b0;
        tif.txt_ready = 1'b1;
        chk($sformatf("%s busy_after", nm), 32'(busy), 32'd0);
        chk($sformatf("%s done_after", nm), 32'(done), 32'd0);
        chk($sformatf("%s we_after", nm), 32'(tif.txt_we), 32'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b0;
        value = '0;
        len = '0;
        lz_blank = 1'b0;
        base_addr = '0;
        tif.txt_ready = 1'b1;

        vecs[0] = '{"beef",   32'h0000BEEF, 4'd4,  1'b0, 12'h050, 4, 64'("BEEF"),     5};
        vecs[1] = '{"lz7",    32'h00000007, 4'd8,  1'b1, 12'h100, 8, 64'("       7"), 9};
        vecs[2] = '{"lz0",    32'h00000000, 4'd8,  1'b1, 12'h200, 8, 64'("       0"), 9};
        vecs[3] = '{"len0",   32'h12345678, 4'd0,  1'b0, 12'h010, 0, 64'(0),          1};
        vecs[4] = '{"len12",  32'h12345678, 4'd12, 1'b0, 12'h000, 8, 64'("12345678"), 9};
        vecs[5] = '{"wrap",   32'h0000ABCD, 4'd4,  1'b0, 12'hFFE, 4, 64'("ABCD"),     5};
        vecs[6] = '{"lzmid",  32'h00000A05, 4'd4,  1'b1, 12'h400, 4, 64'(" A05"),     5};
        vecs[7] = '{"len3",   32'h12345678, 4'd3,  1'b0, 12'h123, 3, 64'("678"),      4};

        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst txt_we", 32'(tif.txt_we), 32'd0);
        chk("rst txt_addr", 32'(tif.txt_addr), 32'd0);
        chk("rst rom_addr", 32'(tif.rom_addr), 32'd0);
        chk("rst txt_data", 32'(tif.txt_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run(vecs[i].name, vecs[i].value, vecs[i].len, vecs[i].lz, vecs[i].base,
                vecs[i].nexp, vecs[i].chars, vecs[i].done_cyc, 0, 0, 0, 0);
        end

        // Back-pressure on the second character.
        run("stall", 32'h00001234, 4'd4, 1'b0, 12'h080, 4, 64'("1234"), 7, 2, 3, 0, 0);

        // Spurious starts during WRITE and during DONE.
        run("ignore", 32'h0000C0DE, 4'd4, 1'b0, 12'h200, 4, 64'("C0DE"), 5, 0, 0, 2, 5);

        // Reset in the middle of a request.
        @(negedge clk);
        start = 1'b1;
        value = 32'h12345678;
        len = 4'd8;
        lz_blank = 1'b0;
        base_addr = 12'h500;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid txt_we", 32'(tif.txt_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst busy", 32'(busy), 32'd0);
        chk("mrst done", 32'(done), 32'd0);
        chk("mrst txt_we", 32'(tif.txt_we), 32'd0);
        chk("mrst txt_addr", 32'(tif.txt_addr), 32'd0);
        chk("mrst rom_addr", 32'(tif.rom_addr), 32'd0);
        chk("mrst txt_data", 32'(tif.txt_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("after_rst", 32'h0000F00D, 4'd4, 1'b1, 12'h600, 4, 64'("F00D"), 5, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
